// File: rtl/mux_arb_pkg.sv
// Shared types and limits for the round-robin mux arbiter.
// The ARB/LOCKED state type is only used when MUX_ARB_LOCK_EN is defined.
package mux_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted req scanning upward from ptr+1, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    j          = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found         = 1'b1;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage through an N:1 mux.
// Define MUX_ARB_LOCK_EN to hold the grant on one requester until its up_last beat.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     up_valid,
  input  logic [N*W-1:0]   up_data,
  input  logic [N-1:0]     up_last,
  output logic [N-1:0]     up_ready,
  output logic             down_valid,
  output logic [W-1:0]     down_data,
  output logic             down_last,
  input  logic             down_ready,
  output logic [IDX_W-1:0] grant_idx
);

  logic             load;
  logic             xfer;
  logic [N-1:0]     elig;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_q;
  logic [W-1:0]     sel_data;
  logic             sel_last;

  logic             down_valid_q;
  logic [W-1:0]     down_data_q;
  logic             down_last_q;
  logic [IDX_W-1:0] grant_idx_q;

  // Gating with rst guarantees no upstream beat is accepted into a stage being cleared.
  assign load     = (!down_valid_q || down_ready) && !rst;
  assign up_ready = load ? gnt_onehot : '0;
  assign xfer     = load && (|gnt_onehot);

`ifdef MUX_ARB_LOCK_EN
  arb_state_t       state_q;
  logic [IDX_W-1:0] lock_idx_q;

  always_comb begin
    elig = up_valid;
    if (state_q == LOCKED) begin
      for (int unsigned i = 0; i < N; i++) begin
        elig[i] = up_valid[i] && (lock_idx_q == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      lock_idx_q <= '0;
    end else if (xfer) begin
      if (state_q == ARB && !sel_last) begin
        state_q    <= LOCKED;
        lock_idx_q <= gnt_idx;
      end else if (state_q == LOCKED && sel_last) begin
        state_q <= ARB;
      end
    end
  end
`else
  assign elig = up_valid;
`endif

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req       (elig),
    .ptr       (ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_onehot[i]) begin
        sel_data = up_data[i*W +: W];
        sel_last = up_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_last_q  <= 1'b0;
      grant_idx_q  <= '0;
      ptr_q        <= IDX_W'(N - 1);
    end else if (xfer) begin
      down_valid_q <= 1'b1;
      down_data_q  <= sel_data;
      down_last_q  <= sel_last;
      grant_idx_q  <= gnt_idx;
      ptr_q        <= gnt_idx;
    end else if (down_ready) begin
      down_valid_q <= 1'b0;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_last  = down_last_q;
  assign grant_idx  = grant_idx_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed steps plus random traffic vs a reference model.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     up_valid;
  logic [N*W-1:0]   up_data;
  logic [N-1:0]     up_last;
  logic [N-1:0]     up_ready;
  logic             down_valid;
  logic [W-1:0]     down_data;
  logic             down_last;
  logic             down_ready;
  logic [IDX_W-1:0] grant_idx;

  int total = 0;
  int bad = 0;

  // Reference model state
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_last;
  int           m_grant;
  bit           m_locked;
  int           m_lock;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_last   (up_last),
    .up_ready  (up_ready),
    .down_valid(down_valid),
    .down_data (down_data),
    .down_last (down_last),
    .down_ready(down_ready),
    .grant_idx (grant_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First eligible requester after m_ptr, wrapping; -1 when none.
  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (up_valid[j] && (!m_locked || j == m_lock)) return j;
    end
    return -1;
  endfunction

  task automatic cycle();
    int           w;
    bit           ld;
    bit           r;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] wdata;
    bit           wlast;
    #1;
    r = rst;
    ld = !m_valid || down_ready;
    ld = ld && !r;
    w = winner();
    exp_rdy = '0;
    wdata = '0;
    wlast = 1'b0;
    if (w >= 0) begin
      wdata = up_data[w*W +: W];
      wlast = up_last[w];
    end
    if (ld && w >= 0) exp_rdy[w] = 1'b1;
    chk("up_ready", 32'(up_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = '0; m_last = 0; m_grant = 0; m_ptr = N - 1; m_locked = 0;
    end else if (ld && w >= 0) begin
      m_valid = 1; m_data = wdata; m_last = wlast; m_grant = w; m_ptr = w;
`ifdef MUX_ARB_LOCK_EN
      if (!m_locked && !wlast) begin
        m_locked = 1;
        m_lock = w;
      end else if (m_locked && wlast) begin
        m_locked = 0;
      end
`endif
    end else if (down_ready) begin
      m_valid = 0;
    end
    #1;
    chk("down_valid", 32'(down_valid), 32'(m_valid));
    chk("down_data", 32'(down_data), 32'(m_data));
    chk("down_last", 32'(down_last), 32'(m_last));
    chk("grant_idx", 32'(grant_idx), 32'(m_grant));
  endtask

  initial begin
    m_ptr = N - 1; m_valid = 0; m_data = '0; m_last = 0; m_grant = 0;
    m_locked = 0; m_lock = 0;
    rst = 1'b1;
    up_valid = '0;
    up_data = '0;
    up_last = '1;
    down_ready = 1'b0;

    // 1: reset then idle
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    chk("t1_valid", 32'(down_valid), 0);
    chk("t1_data", 32'(down_data), 0);
    chk("t1_grant", 32'(grant_idx), 0);
    chk("t1_ready", 32'(up_ready), 0);

    // 2: all requesting, full rate rotation
    up_valid = 4'b1111;
    for (int i = 0; i < N; i++) up_data[i*W +: W] = 8'hA0 + 8'(i);
    down_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_data", 32'(down_data), 32'(8'hA0 + 8'(i % 4)));
      chk("t2_grant", 32'(grant_idx), 32'(i % 4));
    end

    // 3: single requester with a 3-cycle stall
    up_valid = 4'b0100;
    up_data[2*W +: W] = 8'h55;
    cycle();
    chk("t3_accept", 32'(down_data), 32'h55);
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold", 32'(down_data), 32'h55);
      chk("t3_stall_rdy", 32'(up_ready), 0);
    end
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_resume_valid", 32'(down_valid), 1);
      chk("t3_resume_grant", 32'(grant_idx), 2);
    end

    // 4: wrap-around from ptr=1
    for (int i = 0; i < N; i++) up_data[i*W +: W] = 8'h10 + 8'(i);
    up_valid = 4'b0010;
    cycle();
    chk("t4_g1", 32'(grant_idx), 1);
    up_valid = 4'b1001;
    cycle();
    chk("t4_g3", 32'(grant_idx), 3);
    chk("t4_d3", 32'(down_data), 32'h13);
    cycle();
    chk("t4_g0", 32'(grant_idx), 0);

    // 5: reset while stalled
    up_valid = 4'b1111;
    cycle();
    down_ready = 1'b0;
    cycle();
    chk("t5_stalled", 32'(down_valid), 1);
    rst = 1'b1;
    cycle();
    chk("t5_cleared", 32'(down_valid), 0);
    rst = 1'b0;
    down_ready = 1'b1;
    cycle();
    chk("t5_grant0", 32'(grant_idx), 0);

`ifdef MUX_ARB_LOCK_EN
    // 6: locked burst from requester 1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    up_last = '1;
    up_valid = 4'b0001;
    cycle();
    chk("t6_pre", 32'(grant_idx), 0);
    up_valid = 4'b0111;
    up_last = 4'b1101;
    cycle();
    chk("t6_b0", 32'(grant_idx), 1);
    cycle();
    chk("t6_b1", 32'(grant_idx), 1);
    up_last = 4'b1111;
    cycle();
    chk("t6_b2", 32'(grant_idx), 1);
    chk("t6_b2_last", 32'(down_last), 1);
    cycle();
    chk("t6_next", 32'(grant_idx), 2);
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      up_valid = N'($urandom);
      up_data = {$urandom};
      up_last = N'($urandom);
      down_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one mux-based output channel among N requesters.
- Each requester presents valid/data and gets a ready; the winner's data passes through an N:1 mux into a single registered output stage with a valid/ready handshake.
- Sits in front of any shared downstream consumer, and drives the select of the shared mux datapath.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width per requester
IDX_W, $clog2(N), width of the grant index (derived, not overridden)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
up_valid  input  N  per-requester valid
up_data  input  N*W  flattened requester data; requester i at bits [i*W +: W]
up_last  input  N  per-requester end-of-burst flag; used only with MUX_ARB_LOCK_EN
up_ready  output  N  per-requester accept, one-hot or zero
down_valid  output  1  output stage holds a beat
down_data  output  W  output beat data
down_last  output  1  up_last of the held beat
down_ready  input  1  consumer accepts
grant_idx  output  IDX_W  index of the requester whose beat is in the output stage

Behaviour:
- Reset values: down_valid=0, down_data=0, down_last=0, grant_idx=0, rr pointer=N-1 (requester 0 has top priority after reset), lock=0.
- A rising edge with rst=1 discards any beat held in the output stage. No beat is lost from an upstream requester, because no up_ready fired in that cycle.
- load = !down_valid || down_ready. A full stage may refill in the same cycle it drains, giving 1 beat/cycle throughput.
- Winner is combinational: the first i with up_valid[i]=1, scanning from (ptr+1) mod N upward with wrap-around.
- up_ready[winner]=load, all other up_ready=0. With no up_valid asserted, up_ready=0.
- Transfer i happens when up_valid[i] && up_ready[i]. On the next edge:
  - down_data and down_last take requester i's data and last.
  - down_valid=1, grant_idx=i, ptr=i.
- Latency: a beat accepted in cycle t is visible on down_* in cycle t+1.
- load=1 with no upstream transfer: down_valid goes to 0 on the next edge if it was drained, otherwise it holds.
- When down_valid=1 and down_ready=0, down_data, down_last and grant_idx are held stable and all up_ready are 0.
- The rr pointer updates only on a transfer. Idle cycles do not rotate priority.
- up_valid may drop without a handshake. The arbiter does not latch requests; the winner is recomputed every cycle.
- Single requester: served every cycle at full rate.
- All N requesting continuously: grants cycle 0,1,..,N-1,0,... with no requester starved beyond N-1 beats.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Two-state FSM: ARB and LOCKED.
  - In ARB, a transfer with up_last=0 moves to LOCKED with lock_idx=i.
  - In LOCKED, only lock_idx is eligible; up_ready for the others is 0 even if lock_idx is not valid.
  - A transfer from lock_idx with up_last=1 returns to ARB.
  - rst returns to ARB.
- Undefined:
  - No FSM; every beat is arbitrated independently.
  - up_last is passed through to down_last only.

Decomposition:
- Package mux_arb_pkg holds typedef enum logic {ARB, LOCKED} arb_state_t and the N range limit constants.
- One natural sub-module: rr_pick, a combinational block with inputs req[N] and ptr and outputs gnt_onehot and gnt_idx.
- The N:1 data mux and the output register stay in the top level.

Test Plan:
1. rst=1 for 2 cycles, then idle with up_valid=0 -> down_valid=0, down_data=0, grant_idx=0, up_ready=0.
2. N=4, all up_valid=1, data i=8'hA0+i, down_ready=1 -> down_data A0,A1,A2,A3,A0 on consecutive cycles, grant_idx 0,1,2,3,0.
3. Only req 2 valid (8'h55), down_ready=0 for 3 cycles after the first accept -> down_data=55 held, up_ready=0000 while stalled; resumes 1 beat/cycle after down_ready=1.
4. ptr=1 after granting 1, req 0 and 3 valid -> req 3 granted first (wrap-around), then req 0.
5. rst asserted while down_valid=1 and down_ready=0 -> next cycle down_valid=0, and the following grant goes to requester 0 when all request.
6. MUX_ARB_LOCK_EN defined: req 1 sends 3 beats with last=0,0,1 while req 0 and 2 are valid -> the three req-1 beats appear back-to-back, then req 2 is granted.
